ram_bank_ctrl: RTL and testbench

- Parametrised successor of the testbench data RAM, used as the CPU data memory and as a general scratch memory.
- Adds:
  - a valid/ready request channel;
  - a configurable read-pipeline latency;
  - an in-order response queue with backpressure;
  - out-of-range address error reporting.
- Byte-lane write semantics match the existing data RAM.
- Sits between the CPU load/store unit (or a bus adapter) and on-chip storage.

---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_bank_ctrl_resp_fifo.sv | 65 ++++++
 rtl/ram_bank_ctrl.sv | 151 +++++++++++++++
 tb/tb_ram_bank_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM bank controller: default widths, the response
// record and the byte-lane merge used on partial writes.
package ram_pkg;

   localparam int DATA_W_DFLT = 32;
   localparam int STRB_W      = DATA_W_DFLT / 8;

   typedef struct packed {
      logic [DATA_W_DFLT-1:0] rdata;
      logic                   err;
   } resp_t;

   // Lane-masked merge of one byte: new data where enabled, old data elsewhere.
   function automatic logic [7:0] lane_merge(input logic [7:0] old_byte,
                                             input logic [7:0] new_byte,
                                             input logic       en);
      return en ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/ram_bank_ctrl_resp_fifo.sv
// Response queue: synchronous FIFO with asynchronous active-low reset on the
// pointers/count only; storage itself is never reset.
module resp_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [W-1:0]                 din,
   input  logic                         pop,
   output logic [W-1:0]                 dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     buf_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign dout    = buf_mem[rd_ptr_reg];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         buf_mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         end
         if (do_pop) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/ram_bank_ctrl.sv
// Single-port word RAM behind a valid/ready request channel, with a fixed read
// latency pipeline, an in-order response queue and out-of-range error reporting.
module ram_bank_ctrl
   import ram_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DFLT,
   parameter int ADDR_W  = 22,
   parameter int WORDS   = 256,
   parameter int RD_LAT  = 1,
   parameter int Q_DEPTH = RD_LAT + 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W/8-1:0] req_wstrb,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err
);

   localparam int LANES = DATA_W / 8;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int OUT_W = $clog2(Q_DEPTH + RD_LAT + 1);
   localparam int CNT_W = $clog2(Q_DEPTH + 1);
   localparam logic [ADDR_W:0] WORDS_L = (ADDR_W + 1)'(WORDS);

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              err;
   } bank_resp_t;

   typedef struct packed {
      logic       vld;
      bank_resp_t resp;
   } stage_t;

   logic [DATA_W-1:0] mem [WORDS];
   stage_t            pipe_reg [RD_LAT];
   logic              ready_reg;

   logic              accept;
   logic              in_range;
   logic              is_write;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] mem_word;
   logic [DATA_W-1:0] merged_word;
   stage_t            entry;
   stage_t            tail;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   bank_resp_t        fifo_dout;
   bank_resp_t        head;
   logic [OUT_W-1:0]  outstanding;

   assign in_range = ({1'b0, req_addr} < WORDS_L);
   assign idx      = req_addr[IDX_W-1:0];
   assign is_write = |req_wstrb;
   assign accept   = req_valid && req_ready;
   assign mem_word = mem[idx];

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign merged_word[gi*8 +: 8] = lane_merge(mem_word[gi*8 +: 8],
                                                    req_wdata[gi*8 +: 8],
                                                    req_wstrb[gi]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (accept && in_range && is_write) begin
         mem[idx] <= merged_word;
      end
   end

   // Writes and out-of-range requests carry zero data; only in-range reads sample memory.
   always_comb begin
      entry            = '0;
      entry.vld        = accept;
      entry.resp.err   = !in_range;
      entry.resp.rdata = (in_range && !is_write) ? mem_word : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_reg   <= 1'b0;
         pipe_reg[0] <= '0;
      end else begin
         ready_reg   <= 1'b1;
         pipe_reg[0] <= entry;
      end
   end

   generate
      for (gi = 1; gi < RD_LAT; gi++) begin : g_stage
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pipe_reg[gi] <= '0;
            end else begin
               pipe_reg[gi] <= pipe_reg[gi-1];
            end
         end
      end
   endgenerate

   assign tail = pipe_reg[RD_LAT-1];

   // An empty queue lets the pipeline tail bypass straight to the response port,
   // which keeps RD_LAT=1 at single-cycle timing.
   always_comb begin
      head       = fifo_empty ? tail.resp : fifo_dout;
      resp_valid = tail.vld || !fifo_empty;
      resp_rdata = resp_valid ? head.rdata : '0;
      resp_err   = resp_valid ? head.err : 1'b0;
      fifo_pop   = resp_ready && !fifo_empty;
      fifo_push  = tail.vld && !fifo_full && !(fifo_empty && resp_ready);
   end

   resp_fifo #(
      .W     (DATA_W + 1),
      .DEPTH (Q_DEPTH)
   ) u_resp_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .din   (tail.resp),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Credit counts only registered state, so req_ready never follows resp_ready combinationally.
   always_comb begin
      outstanding = OUT_W'(fifo_count);
      for (int k = 0; k < RD_LAT; k++) begin
         outstanding = outstanding + OUT_W'(pipe_reg[k].vld);
      end
      req_ready = ready_reg && (outstanding < OUT_W'(Q_DEPTH));
   end

endmodule

// File: tb/tb_ram_bank_ctrl.sv
// Self-checking bench for ram_bank_ctrl: directed steps plus random traffic
// against a transaction-level model, and a latency sweep over RD_LAT=1..4.
module tb_ram_bank_ctrl;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 22;
   localparam int WORDS   = 256;
   localparam int RD_LAT  = 2;
   localparam int Q_DEPTH = RD_LAT + 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [3:0]        req_wstrb;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic              resp_err;

   logic              lat_valid;
   logic [ADDR_W-1:0] lat_addr;
   logic [3:0]        lat_wstrb;
   logic [31:0]       lat_wdata;
   logic              lat_ready [4];
   logic              lat_rvalid [4];
   logic [31:0]       lat_rdata [4];
   logic              lat_err [4];

   always #5 clk = ~clk;

   ram_bank_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WORDS(WORDS),
                   .RD_LAT(RD_LAT), .Q_DEPTH(Q_DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wstrb(req_wstrb), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lat
         ram_bank_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WORDS(WORDS),
                         .RD_LAT(gi + 1)) u_lat (
            .clk(clk), .rst_n(rst_n),
            .req_valid(lat_valid), .req_ready(lat_ready[gi]), .req_addr(lat_addr),
            .req_wstrb(lat_wstrb), .req_wdata(lat_wdata),
            .resp_valid(lat_rvalid[gi]), .resp_ready(1'b1),
            .resp_rdata(lat_rdata[gi]), .resp_err(lat_err[gi])
         );
      end
   endgenerate

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          ready_edge;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mem_m [WORDS];
   int          n_chk = 0;
   int          n_err = 0;
   int          edge_cnt = 0;
   bit          rdy_model = 1'b0;
   bit          last_acc;
   int          dut_acc = 0;
   int          n_pops = 0;
   logic [31:0] last_rdata;
   logic        last_err;
   int          last_pop_edge = 0;
   int          prev_pop_edge = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // One clock: check outputs at the falling edge, then update the model at the rising edge.
   task automatic cycle();
      bit   exp_valid;
      bit   exp_ready;
      exp_t e;
      @(negedge clk);
      exp_ready = rdy_model && (q.size() < Q_DEPTH);
      exp_valid = (q.size() > 0) && (q[0].ready_edge <= edge_cnt);
      chk("req_ready", req_ready, exp_ready);
      chk("resp_valid", resp_valid, exp_valid);
      if (exp_valid) begin
         chk("resp_rdata", resp_rdata, q[0].rdata);
         chk("resp_err", resp_err, q[0].err);
      end
      if (req_valid && req_ready) dut_acc++;
      if (resp_valid && resp_ready) begin
         n_pops++;
         last_rdata    = resp_rdata;
         last_err      = resp_err;
         prev_pop_edge = last_pop_edge;
         last_pop_edge = edge_cnt;
      end
      last_acc = req_valid && exp_ready;
      @(posedge clk);
      edge_cnt++;
      rdy_model = 1'b1;
      if (exp_valid && resp_ready) void'(q.pop_front());
      if (last_acc) begin
         e.ready_edge = edge_cnt + RD_LAT - 1;
         e.rdata      = '0;
         e.err        = (req_addr >= WORDS);
         if (!e.err) begin
            if (req_wstrb == 4'h0) begin
               e.rdata = mem_m[req_addr[7:0]];
            end else begin
               for (int b = 0; b < 4; b++)
                  if (req_wstrb[b]) mem_m[req_addr[7:0]][b*8 +: 8] = req_wdata[b*8 +: 8];
            end
         end
         q.push_back(e);
      end
      #1;
   endtask

   task automatic issue(input int addr, input logic [3:0] strb, input logic [31:0] data);
      req_valid = 1'b1;
      req_addr  = ADDR_W'(addr);
      req_wstrb = strb;
      req_wdata = data;
      last_acc  = 1'b0;
      for (int i = 0; i < 50 && !last_acc; i++) cycle();
      chk("issue_accept", last_acc, 1'b1);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && q.size() > 0; i++) cycle();
   endtask

   task automatic do_reset(input bit mid_run);
      rst_n     = 1'b0;
      rdy_model = 1'b0;
      q.delete();
      if (mid_run) begin
         #1;
         chk("rst_async_valid", resp_valid, 1'b0);
         chk("rst_async_ready", req_ready, 1'b0);
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", req_ready, 1'b0);
      chk("rst_valid", resp_valid, 1'b0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_err", resp_err, 1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      int acc0;
      int pops0;
      int seen [4];
      rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wstrb = '0; req_wdata = '0;
      resp_ready = 1'b1;
      lat_valid = 1'b0; lat_addr = '0; lat_wstrb = '0; lat_wdata = '0;
      do_reset(1'b0);

      for (int a = 0; a < WORDS; a++) issue(a, 4'hF, $urandom);
      issue(0, 4'hF, 32'hFFFFFFFF);
      issue(5, 4'hF, 32'hDEADBEEF);
      issue(44, 4'hF, 32'h12345678);
      drain();

      issue(0, 4'b0010, 32'h00000100);
      drain();
      chk("bw_wr_err", last_err, 1'b0);
      chk("bw_wr_rdata", last_rdata, 32'h0);
      issue(0, 4'h0, 32'h0);
      drain();
      chk("bw_lane1", last_rdata, 32'hFFFF01FF);
      issue(0, 4'hF, 32'hFFFFFFFF);
      issue(0, 4'b1100, 32'h00010000);
      issue(0, 4'h0, 32'h0);
      drain();
      chk("bw_lane23", last_rdata, 32'h0001FFFF);

      issue(256, 4'h0, 32'h0);
      drain();
      chk("oor_rd_err", last_err, 1'b1);
      chk("oor_rd_rdata", last_rdata, 32'h0);
      issue(300, 4'hF, 32'hCAFEF00D);
      drain();
      chk("oor_wr_err", last_err, 1'b1);
      issue(44, 4'h0, 32'h0);
      drain();
      chk("oor_wr_no_alias", last_rdata, 32'h12345678);

      issue(7, 4'hF, 32'h00000034);
      issue(7, 4'h0, 32'h0);
      drain();
      chk("raw_data", last_rdata, 32'h00000034);
      chk("raw_back_to_back", 32'(last_pop_edge - prev_pop_edge), 32'd1);

      resp_ready = 1'b0;
      acc0 = dut_acc;
      req_valid = 1'b1;
      req_wstrb = 4'h0;
      for (int k = 0; k < 8; k++) begin
         req_addr = ADDR_W'(10 + k);
         cycle();
      end
      chk("bp_accepts", 32'(dut_acc - acc0), 32'(Q_DEPTH));
      chk("bp_full_ready", req_ready, 1'b0);
      req_valid = 1'b0;
      resp_ready = 1'b1;
      pops0 = n_pops;
      drain();
      chk("bp_drained", 32'(n_pops - pops0), 32'(Q_DEPTH));
      cycle();
      chk("bp_ready_back", req_ready, 1'b1);

      resp_ready = 1'b0;
      issue(1, 4'h0, 32'h0);
      issue(2, 4'h0, 32'h0);
      issue(3, 4'h0, 32'h0);
      do_reset(1'b1);
      resp_ready = 1'b1;
      pops0 = n_pops;
      repeat (8) cycle();
      chk("rst_no_resp", 32'(n_pops - pops0), 32'd0);
      chk("rst_ready_after", req_ready, 1'b1);
      issue(5, 4'h0, 32'h0);
      drain();
      chk("rst_mem_kept", last_rdata, 32'hDEADBEEF);

      for (int n = 0; n < 400; n++) begin
         req_valid  = ($urandom % 4) != 0;
         req_addr   = ADDR_W'($urandom_range(8, 299));
         req_wstrb  = ($urandom % 2) ? 4'($urandom) : 4'h0;
         req_wdata  = $urandom;
         resp_ready = ($urandom % 4) != 0;
         cycle();
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      drain();

      lat_valid = 1'b1; lat_addr = ADDR_W'(3); lat_wstrb = 4'hF; lat_wdata = 32'h92A2B2C2;
      @(posedge clk); #1;
      lat_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      lat_valid = 1'b1; lat_wstrb = 4'h0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("lat%0d_ready", i + 1), lat_ready[i], 1'b1);
         seen[i] = -1;
      end
      @(posedge clk); #1;
      lat_valid = 1'b0;
      for (int e = 0; e < 8; e++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (lat_rvalid[i] && seen[i] < 0) begin
               seen[i] = e;
               chk($sformatf("lat%0d_rdata", i + 1), lat_rdata[i], 32'h92A2B2C2);
               chk($sformatf("lat%0d_err", i + 1), lat_err[i], 1'b0);
            end
         end
         @(posedge clk);
      end
      for (int i = 0; i < 4; i++) chk($sformatf("lat%0d_cycles", i + 1), 32'(seen[i]), 32'(i));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
